// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit: one radix-2 step per cycle, sign fixup in a final cycle.
// Also handles MTHI/MTLO writes and stalls the pipeline while an operation is in flight.

// state | meaning
// IDLE  | HI/LO stable; accepts start or MTHI/MTLO
// CALC  | 32 shift-add / restoring shift-subtract iterations
// FIX   | sign fixup, HI/LO write, done pulse
module muldiv_sequencer #(
    parameter logic [1:0] OP_MULT  = 2'b00,
    parameter logic [1:0] OP_MULTU = 2'b01,
    parameter logic [1:0] OP_DIV   = 2'b10,
    parameter logic [1:0] OP_DIVU  = 2'b11
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] mt_data,
    input  logic        mf_req,
    input  logic        flush,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_next;
    logic [5:0]  count;
    logic [1:0]  op_q;
    logic        sign_a, sign_b;
    logic [31:0] acc_hi, acc_lo, mcand;

    logic        in_signed, in_sign_a, in_sign_b;
    logic [31:0] in_mag_a, in_mag_b;
    logic        is_div;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && !flush) state_next = CALC;
            CALC: begin
                if (flush)               state_next = IDLE;
                else if (count == 6'd31) state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        stall = busy & (start | mf_req | mthi | mtlo);
    end

    // Operands are reduced to magnitudes up front so one unsigned datapath serves all four ops.
    always_comb begin
        in_signed = (op == OP_MULT) || (op == OP_DIV);
        in_sign_a = in_signed & src_a[31];
        in_sign_b = in_signed & src_b[31];
        in_mag_a  = in_sign_a ? -src_a : src_a;
        in_mag_b  = in_sign_b ? -src_b : src_b;
    end

    always_comb begin
        is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? mcand : 32'd0)};
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = div_shift - {1'b0, mcand};
        prod_fix  = (sign_a ^ sign_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix   = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
        rem_fix   = sign_a ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            count    <= '0;
            op_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mcand    <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (!flush) begin
                        if (start) begin
                            op_q   <= op;
                            sign_a <= in_sign_a;
                            sign_b <= in_sign_b;
                            count  <= '0;
                            acc_hi <= '0;
                            // multiply: acc_lo holds the multiplier; divide: the dividend
                            acc_lo <= ((op == OP_DIV) || (op == OP_DIVU)) ? in_mag_a : in_mag_b;
                            mcand  <= ((op == OP_DIV) || (op == OP_DIVU)) ? in_mag_b : in_mag_a;
                        end else begin
                            if (mthi) hi <= mt_data;
                            if (mtlo) lo <= mt_data;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        count <= count + 6'd1;
                        if (is_div) begin
                            if (!div_diff[32]) begin
                                acc_hi <= div_diff[31:0];
                                acc_lo <= {acc_lo[30:0], 1'b1};
                            end else begin
                                acc_hi <= div_shift[31:0];
                                acc_lo <= {acc_lo[30:0], 1'b0};
                            end
                        end else begin
                            acc_hi <= mul_sum[32:1];
                            acc_lo <= {mul_sum[0], acc_lo[31:1]};
                        end
                    end
                end
                FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            if (mcand == 32'd0) begin
                                div_zero <= 1'b1;
                            end else begin
                                hi <= rem_fix;
                                lo <= quo_fix;
                            end
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: expected HI/LO results are queued at issue time
// and a monitor compares them whenever done pulses.
module tb_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        mthi, mtlo;
    logic [31:0] mt_data;
    logic        mf_req, flush;
    logic        busy, stall;
    logic [31:0] hi, lo;
    logic        done, div_zero;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    muldiv_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
        .mt_data(mt_data), .mf_req(mf_req), .flush(flush),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo),
        .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every done must match the oldest queued expectation
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (div_zero && !done) chk("div_zero_without_done", 1, 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result_hi", hi, e.hi);
                    chk("result_lo", lo, e.lo);
                    chk("result_div_zero", div_zero, e.dz);
                    chk("result_latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic expect_res, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input logic with_mt);
        exp_t e;
        @(negedge clock);
        start = 1'b1; op = o; src_a = a; src_b = b;
        if (with_mt) begin
            mthi = 1'b1; mt_data = 32'hDEAD;
        end
        if (expect_res) begin
            e.hi = ehi; e.lo = elo; e.dz = edz; e.cyc = cyc + 34;
            exp_q.push_back(e);
        end
        @(negedge clock);
        start = 1'b0; mthi = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100 && busy; i++) @(negedge clock);
        chk({name, "_timeout"}, busy, 0);
    endtask

    task automatic mt_write(input logic h, input logic l, input logic [31:0] d);
        @(negedge clock);
        mthi = h; mtlo = l; mt_data = d;
        @(negedge clock);
        mthi = 1'b0; mtlo = 1'b0;
    endtask

    initial begin
        logic stall_bad;
        reset = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        mthi = 1'b0; mtlo = 1'b0; mt_data = '0; mf_req = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clock);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_div_zero", div_zero, 0);
        reset = 1'b1;

        issue(MULT, 32'hFFFFFFFE, 32'h00000003, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0);
        chk("busy_during_calc", busy, 1);
        wait_idle("mult_neg");
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0, 0);
        wait_idle("multu_max");
        issue(MULT, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h00000000, 0, 0);
        wait_idle("mult_minmin");
        issue(DIV, 32'hFFFFFFF9, 32'h00000002, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        wait_idle("div_neg");
        issue(DIVU, 32'd7, 32'd2, 1, 32'd1, 32'd3, 0, 0);
        wait_idle("divu_7_2");
        issue(DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 0, 0);
        wait_idle("div_overflow");
        issue(DIV, 32'd7, 32'hFFFFFFFE, 1, 32'd1, 32'hFFFFFFFD, 0, 0);
        wait_idle("div_pos_neg");
        issue(DIVU, 32'hFFFFFFFF, 32'h10, 1, 32'hF, 32'h0FFFFFFF, 0, 0);
        wait_idle("divu_big");

        mt_write(1, 1, 32'hABCD);
        chk("mt_both_hi", hi, 32'hABCD);
        chk("mt_both_lo", lo, 32'hABCD);
        mt_write(1, 0, 32'h11);
        mt_write(0, 1, 32'h22);
        chk("mthi_only", hi, 32'h11);
        chk("mtlo_only", lo, 32'h22);

        // divide by zero, with an MTHI arriving mid-operation that must be ignored
        issue(DIVU, 32'd5, 32'd0, 1, 32'h11, 32'h22, 1, 0);
        repeat (3) @(negedge clock);
        mthi = 1'b1; mt_data = 32'h99;
        #1 chk("stall_on_mthi_busy", stall, 1);
        @(negedge clock);
        mthi = 1'b0;
        wait_idle("divu_zero");
        chk("hi_after_div_zero", hi, 32'h11);

        // start together with MTHI in IDLE: the MT write is dropped
        issue(MULTU, 32'd2, 32'd3, 1, 32'd0, 32'd6, 0, 1);
        wait_idle("start_with_mt");

        // MFHI/MFLO arriving mid-operation stalls until the result lands
        issue(MULT, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
        repeat (4) @(negedge clock);
        mf_req = 1'b1;
        stall_bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (!busy) break;
            if (!stall) stall_bad = 1'b1;
            @(negedge clock);
        end
        chk("mf_stall_while_busy", stall_bad, 0);
        chk("mf_busy_released", busy, 0);
        chk("mf_stall_released", stall, 0);
        chk("mf_hi_ready", hi, 32'hFFFFFFFF);
        chk("mf_lo_ready", lo, 32'hFFFFFFEB);
        @(negedge clock);
        mf_req = 1'b0;

        // flush mid-CALC: no write, no done, immediate restart works
        issue(MULT, 32'd5, 32'd5, 0, 0, 0, 0, 0);
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_hi", hi, 32'hFFFFFFFF);
        chk("flush_lo", lo, 32'hFFFFFFEB);
        issue(MULTU, 32'd2, 32'd3, 1, 32'd0, 32'd6, 0, 0);
        wait_idle("after_flush");

        // flush together with start in IDLE is not accepted
        @(negedge clock);
        start = 1'b1; flush = 1'b1; op = MULTU; src_a = 32'd9; src_b = 32'd9;
        @(negedge clock);
        start = 1'b0; flush = 1'b0;
        chk("flush_blocks_start", busy, 0);

        // reset mid-CALC clears HI/LO and discards the operation
        mt_write(1, 0, 32'h55);
        issue(MULT, 32'h1234, 32'h10, 0, 0, 0, 0, 0);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("midreset_hi", hi, 0);
        chk("midreset_lo", lo, 0);
        chk("midreset_busy", busy, 0);
        reset = 1'b1;

        repeat (40) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
